// File: rtl/card_shoe_arbiter.sv
// card_shoe_arbiter: finite card shoe with per-rank counts, LFSR-seeded draw and player/dealer round-robin
module card_shoe_arbiter #(
    parameter int         DECKS     = 1,
    parameter logic [4:0] LFSR_SEED = 5'b00010
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       shuffle,
    input  logic       p_req,
    input  logic       d_req,
    output logic       p_gnt,
    output logic       d_gnt,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic [7:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, REFILL, SCAN, GRANT} state_t;

    localparam logic [4:0] FULL_RANK = 5'(4 * DECKS);
    localparam logic [7:0] FULL_SHOE = 8'(52 * DECKS);

    state_t     state, state_n;
    logic [4:0] lfsr;
    logic [4:0] cnt [1:13];
    logic [3:0] cand, first_cand;
    logic       target, prio_d, pend, sel_d, hit, start;

    // draw candidate, requester choice and scan hit derived from current state
    always_comb begin
        first_cand = (lfsr[3:0] >= 4'd13 ? lfsr[3:0] - 4'd13 : lfsr[3:0]) + 4'd1;
        sel_d      = d_req && (!p_req || prio_d);
        hit        = cnt[cand] != 5'd0;
        start      = state == IDLE && !(shuffle || pend) && (p_req || d_req) && cards_left != 8'd0;
    end

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // next-state logic; a pending or fresh shuffle beats any request in IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (shuffle || pend) ? REFILL : start ? SCAN : IDLE;
            REFILL:  state_n = IDLE;
            SCAN:    state_n = hit ? GRANT : SCAN;
            GRANT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // outputs decoded from the registered state
    always_comb begin
        p_gnt      = state == GRANT && !target;
        d_gnt      = state == GRANT && target;
        busy       = state != IDLE;
        deck_empty = cards_left == 8'd0;
    end

    // shoe contents, LFSR, scan candidate, dealt card and arbitration bookkeeping
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            lfsr       <= LFSR_SEED;
            for (int i = 1; i <= 13; i++) cnt[i] <= FULL_RANK;
            cards_left <= FULL_SHOE;
            card_rank  <= 4'd0;
            card_value <= 4'd0;
            cand       <= 4'd1;
            target     <= 1'b0;
            prio_d     <= 1'b0;
            pend       <= 1'b0;
        end else begin
            lfsr <= {lfsr[3:0], ~(lfsr[4] ^ lfsr[2])};
            if (shuffle && state != IDLE) pend <= 1'b1;
            if (start) begin
                target <= sel_d;
                cand   <= first_cand;
            end
            if (state == REFILL) begin
                for (int i = 1; i <= 13; i++) cnt[i] <= FULL_RANK;
                cards_left <= FULL_SHOE;
                pend       <= 1'b0;
            end
            if (state == SCAN) begin
                if (hit) begin
                    cnt[cand]  <= cnt[cand] - 5'd1;
                    cards_left <= cards_left - 8'd1;
                    card_rank  <= cand;
                    card_value <= cand > 4'd10 ? 4'd10 : cand;
                end else begin
                    cand <= cand == 4'd13 ? 4'd1 : cand + 4'd1;
                end
            end
            if (state == GRANT) prio_d <= ~target;
        end
    end
endmodule
